spi_cfg_sequencer: RTL



---
 rtl/spi_cfg_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/spi_cfg_sequencer.sv
// Write-only SPI mode-0 master that queues {1'b1, addr, data} register writes in a small FIFO
// and serialises them MSB first on sclk/ncs/copi for the PWM configuration peripheral.
module spi_cfg_sequencer #(
   parameter int CLK_DIV    = 4,
   parameter int CS_GAP     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_data,
   output logic       sclk,
   output logic       ncs,
   output logic       copi,
   output logic       busy,
   output logic       frame_done,
   output logic [4:0] fifo_level
);

   localparam int         PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
   localparam logic [4:0] DEPTH    = 5'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;

   logic [15:0]      mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [4:0]       level_q, level_d;
   logic             push, pop;

   state_t      state_q;
   logic [7:0]  divCnt_q;
   logic [3:0]  bitCnt_q;
   logic [15:0] shift_q;
   logic        sclk_q, ncs_q, frameDone_q;

   // A full FIFO refuses pushes even if a pop frees a slot in the same cycle.
   assign cmd_ready = (level_q != DEPTH);
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state_q == IDLE) && (level_q != 5'd0);

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      level_d = level_q;
      if (push) wrPtr_d = wrPtr_q + 1'b1;
      if (pop)  rdPtr_d = rdPtr_q + 1'b1;
      if (push && !pop)      level_d = level_q + 5'd1;
      else if (pop && !push) level_d = level_q - 5'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wrPtr_q] <= {1'b1, cmd_addr, cmd_data};
   end

   // copi is the shift register MSB, so it only moves when the engine shifts on a falling sclk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         divCnt_q    <= '0;
         bitCnt_q    <= '0;
         shift_q     <= '0;
         sclk_q      <= 1'b0;
         ncs_q       <= 1'b1;
         frameDone_q <= 1'b0;
      end else begin
         frameDone_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  shift_q  <= mem_q[rdPtr_q];
                  bitCnt_q <= 4'd15;
                  divCnt_q <= '0;
                  ncs_q    <= 1'b0;
                  state_q  <= SETUP;
               end
            end
            SETUP, LOW: begin
               if (divCnt_q == DIV_LAST) begin
                  divCnt_q <= '0;
                  sclk_q   <= 1'b1;
                  state_q  <= HIGH;
               end else begin
                  divCnt_q <= divCnt_q + 8'd1;
               end
            end
            HIGH: begin
               if (divCnt_q == DIV_LAST) begin
                  divCnt_q <= '0;
                  sclk_q   <= 1'b0;
                  if (bitCnt_q == 4'd0) begin
                     ncs_q       <= 1'b1;
                     frameDone_q <= 1'b1;
                     state_q     <= HOLD;
                  end else begin
                     shift_q  <= {shift_q[14:0], 1'b0};
                     bitCnt_q <= bitCnt_q - 4'd1;
                     state_q  <= LOW;
                  end
               end else begin
                  divCnt_q <= divCnt_q + 8'd1;
               end
            end
            // Single cycle with ncs back high and frame_done asserted; copi keeps the last bit.
            HOLD: begin
               divCnt_q <= '0;
               state_q  <= GAP;
            end
            GAP: begin
               if (divCnt_q == GAP_LAST) begin
                  divCnt_q <= '0;
                  state_q  <= IDLE;
               end else begin
                  divCnt_q <= divCnt_q + 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sclk       = sclk_q;
   assign ncs        = ncs_q;
   assign copi       = shift_q[15];
   assign frame_done = frameDone_q;
   assign fifo_level = level_q;
   assign busy       = (level_q != 5'd0) || (state_q != IDLE);

endmodule
